// File: rtl/bus_pkg.sv
// Shared encodings for the two-master bus arbiter: FSM states, owner codes and timeout default.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN1 = 2'd1,
      OWN2 = 2'd2,
      TURN = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      M1   = 2'd1,
      M2   = 2'd2
   } owner_t;

   localparam int DEFAULT_SPLIT_TIMEOUT = 12;

endpackage

// File: rtl/bus_arbiter_if.sv
// Handshake bundle between the two masters, the addressed slave and the bus arbiter.
interface bus_arbiter_if;

   logic       m1_request;
   logic       m2_request;
   logic       bus_busy;
   logic       split;
   logic       split_ready;
   logic       m1_grant;
   logic       m2_grant;
   logic [1:0] bus_owner;
   logic       m1_split;
   logic       m2_split;
   logic       split_timeout;
   logic [1:0] state_out;

   modport master (
      output m1_request, m2_request, bus_busy, split, split_ready,
      input  m1_grant, m2_grant, bus_owner, m1_split, m2_split, split_timeout, state_out
   );

   modport slave (
      input  m1_request, m2_request, bus_busy, split, split_ready,
      output m1_grant, m2_grant, bus_owner, m1_split, m2_split, split_timeout, state_out
   );

endinterface

// File: rtl/bus_arbiter_split_tracker.sv
// Park bookkeeping for split transactions: park flags, park timer, timeout pulse and
// the one-shot priority granted to a master when its park is released.
module split_tracker
   import bus_pkg::*;
#(
   parameter int SPLIT_TIMEOUT = DEFAULT_SPLIT_TIMEOUT,
   parameter int TW            = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic park_m1,
   input  logic park_m2,
   input  logic split_ready,
   input  logic arbitrated,
   output logic m1_split,
   output logic m2_split,
   output logic split_timeout,
   output logic favour_m1,
   output logic favour_m2
);

   localparam logic [TW-1:0] TIMER_LAST = TW'(SPLIT_TIMEOUT - 1);

   logic [TW-1:0] timer;
   logic          parked;
   logic          release_now;
   logic          timeout_hit;

   // split_ready takes precedence over an expiry landing on the same edge
   assign parked      = m1_split | m2_split;
   assign release_now = parked & (split_ready | (timer == TIMER_LAST));
   assign timeout_hit = parked & ~split_ready & (timer == TIMER_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m1_split      <= 1'b0;
         m2_split      <= 1'b0;
         split_timeout <= 1'b0;
         favour_m1     <= 1'b0;
         favour_m2     <= 1'b0;
         timer         <= '0;
      end else begin
         split_timeout <= timeout_hit;
         if (park_m1 | park_m2) begin
            m1_split <= park_m1;
            m2_split <= park_m2;
            timer    <= '0;
         end else if (release_now) begin
            m1_split <= 1'b0;
            m2_split <= 1'b0;
            timer    <= '0;
         end else if (parked) begin
            timer <= timer + 1'b1;
         end
         // A fresh release outranks clearing by an arbitration on the same edge
         if (release_now) begin
            favour_m1 <= m1_split;
            favour_m2 <= m2_split;
         end else if (arbitrated) begin
            favour_m1 <= 1'b0;
            favour_m2 <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with burst hold, turnaround cycle and split parking.
// Optional ARB_ROUND_ROBIN_EN: ties in IDLE go to the master that did not own the bus last.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int SPLIT_TIMEOUT = DEFAULT_SPLIT_TIMEOUT,
   parameter int TW            = 4
) (
   input logic          clk,
   input logic          reset,
   bus_arbiter_if.slave bus
);

   state_t state;
   state_t next_state;
   owner_t pick;
   owner_t tie_pick;
   logic   park_m1;
   logic   park_m2;
   logic   arbitrated;
   logic   elig1;
   logic   elig2;
   logic   parked;
   logic   favour_m1;
   logic   favour_m2;

   split_tracker #(
      .SPLIT_TIMEOUT(SPLIT_TIMEOUT),
      .TW           (TW)
   ) u_split_tracker (
      .clk          (clk),
      .reset        (reset),
      .park_m1      (park_m1),
      .park_m2      (park_m2),
      .split_ready  (bus.split_ready),
      .arbitrated   (arbitrated),
      .m1_split     (bus.m1_split),
      .m2_split     (bus.m2_split),
      .split_timeout(bus.split_timeout),
      .favour_m1    (favour_m1),
      .favour_m2    (favour_m2)
   );

`ifdef ARB_ROUND_ROBIN_EN
   owner_t last_owner;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_owner <= M2;
      end else if (arbitrated) begin
         last_owner <= pick;
      end
   end

   assign tie_pick = (last_owner == M1) ? M2 : M1;
`else
   assign tie_pick = M1;
`endif

   assign parked = bus.m1_split | bus.m2_split;
   assign elig1  = bus.m1_request & ~bus.m1_split;
   assign elig2  = bus.m2_request & ~bus.m2_split;

   always_comb begin
      next_state = state;
      pick       = NONE;
      park_m1    = 1'b0;
      park_m2    = 1'b0;
      arbitrated = 1'b0;
      case (state)
         IDLE: begin
            if (favour_m1 && elig1)      pick = M1;
            else if (favour_m2 && elig2) pick = M2;
            else if (elig1 && elig2)     pick = tie_pick;
            else if (elig1)              pick = M1;
            else if (elig2)              pick = M2;
            arbitrated = (pick != NONE);
            if (pick == M1)      next_state = OWN1;
            else if (pick == M2) next_state = OWN2;
         end
         OWN1: begin
            if (bus.split && !parked) begin
               park_m1    = 1'b1;
               next_state = TURN;
            end else if (!bus.m1_request && !bus.bus_busy) begin
               next_state = TURN;
            end
         end
         OWN2: begin
            if (bus.split && !parked) begin
               park_m2    = 1'b1;
               next_state = TURN;
            end else if (!bus.m2_request && !bus.bus_busy) begin
               next_state = TURN;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Grants are decoded from the next state so they change on the same edge as the FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         bus.m1_grant  <= 1'b0;
         bus.m2_grant  <= 1'b0;
         bus.bus_owner <= NONE;
      end else begin
         state         <= next_state;
         bus.m1_grant  <= (next_state == OWN1);
         bus.m2_grant  <= (next_state == OWN2);
         bus.bus_owner <= (next_state == OWN1) ? M1 : ((next_state == OWN2) ? M2 : NONE);
      end
   end

   assign bus.state_out = state;

endmodule
